// File: rtl/hmmm_pkg.sv
// Shared definitions for the hmmm program loader: default widths and loader states.
package hmmm_pkg;

  localparam int DEF_WORD_W     = 16;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_RST_CYCLES = 2;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    STB_ADDR,
    STB_DATA,
    RELEASE,
    DONE,
    ERR
  } loader_state_e;

  function automatic logic takes_bytes(loader_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DAT_HI) || (s == DAT_LO);
  endfunction

  function automatic logic holds_core(loader_state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/hmmm_loader.sv
// Byte-stream program loader: packs big-endian words, strobes them into hmmm core
// memory at auto-incrementing addresses, then releases core reset.
module hmmm_loader
  import hmmm_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pgrm_addr,
  output logic              pgrm_data,
  output logic [WORD_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  rel_q, rel_d;
  logic [15:0]       n_new;
  logic              xfer;

  logic              in_ready_d, pgrm_addr_d, pgrm_data_d, bus_oe_d;
  logic              core_rst_d, busy_d, done_d, err_d;
  logic [WORD_W-1:0] bus_out_d;

  assign xfer  = in_valid & in_ready;
  assign n_new = {hi_q, in_data};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    hi_d    = hi_q;
    word_d  = word_q;
    rel_d   = rel_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          addr_d  = '0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          count_d = n_new;
          if (n_new == 16'd0)              state_d = RELEASE;
          else if ({1'b0, n_new} > MAX_N)  state_d = ERR;
          else                             state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        if (xfer) begin
          word_d  = WORD_W'({hi_q, in_data});
          state_d = STB_ADDR;
        end
      end
      STB_ADDR: state_d = STB_DATA;
      STB_DATA: begin
        addr_d = addr_q + 1'b1;
        // addr carries one extra bit so a full 2**ADDR_W image still matches N
        if (16'(addr_q) + 16'd1 == count_q) state_d = RELEASE;
        else                                state_d = DAT_HI;
      end
      RELEASE: begin
        if (rel_q == '0) state_d = DONE;
        else             rel_d   = rel_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RELEASE && state_q != RELEASE) rel_d = CNT_W'(RST_CYCLES - 1);
  end

  always_comb begin
    in_ready_d  = takes_bytes(state_d);
    pgrm_addr_d = (state_d == STB_ADDR);
    pgrm_data_d = (state_d == STB_DATA);
    bus_oe_d    = pgrm_addr_d | pgrm_data_d;
    core_rst_d  = holds_core(state_d);
    busy_d      = holds_core(state_d) && (state_d != ERR);
    done_d      = (state_q == RELEASE) && (state_d == DONE);
    err_d       = (state_d == ERR);
    bus_out_d   = '0;
    if (pgrm_addr_d)      bus_out_d = WORD_W'(addr_d[ADDR_W-1:0]);
    else if (pgrm_data_d) bus_out_d = word_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      word_q    <= '0;
      rel_q     <= '0;
      in_ready  <= 1'b0;
      pgrm_addr <= 1'b0;
      pgrm_data <= 1'b0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      core_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      word_q    <= word_d;
      rel_q     <= rel_d;
      in_ready  <= in_ready_d;
      pgrm_addr <= pgrm_addr_d;
      pgrm_data <= pgrm_data_d;
      bus_out   <= bus_out_d;
      bus_oe    <= bus_oe_d;
      core_rst  <= core_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
